// File: rtl/sdram_rv_arbiter_pkg.sv
// Shared types and defaults for the SDRAM RISC-V port arbiter.
package sdram_rv_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_WAIT_ACK,
    ARB_RD_WAIT,
    ARB_DONE
  } rv_arb_state_t;

  localparam int unsigned RV_ARB_NCLI     = 3;
  localparam int unsigned RV_ARB_RD_DELAY = 3;
  localparam int unsigned RV_ARB_AW       = 20;  // word address [20:1]
  localparam int unsigned RV_ARB_DW       = 16;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int unsigned idx_w(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sdram_rv_arbiter_if.sv
// Client-side bundle of the arbiter: level request in, one-cycle ack out.
// master = client side, slave = arbiter side.
interface sdram_rv_arbiter_if
  import sdram_rv_arbiter_pkg::*;
#(
  parameter int unsigned NCLI = RV_ARB_NCLI
) ();

  logic [NCLI-1:0]           c_req;
  logic [NCLI-1:0]           c_we;
  logic [NCLI*RV_ARB_AW-1:0] c_addr;
  logic [NCLI*RV_ARB_DW-1:0] c_wdata;
  logic [NCLI*2-1:0]         c_ds;
  logic [NCLI-1:0]           c_ack;
  logic [RV_ARB_DW-1:0]      c_rdata;

  modport master (
    output c_req, c_we, c_addr, c_wdata, c_ds,
    input  c_ack, c_rdata
  );

  modport slave (
    input  c_req, c_we, c_addr, c_wdata, c_ds,
    output c_ack, c_rdata
  );

endinterface

// File: rtl/sdram_rv_arbiter_pick.sv
// Combinational one-hot grant picker.
// Default: round-robin, search starts after last_i and wraps.
// RV_ARB_FIXED_PRIO_EN: fixed priority, lowest index wins, no pointer input.
module sdram_rv_arbiter_pick
  import sdram_rv_arbiter_pkg::*;
#(
  parameter int unsigned NCLI = RV_ARB_NCLI,
  localparam int unsigned IdxW = idx_w(NCLI)
) (
  input  logic [NCLI-1:0] req_i,
`ifndef RV_ARB_FIXED_PRIO_EN
  input  logic [IdxW-1:0] last_i,
  output logic [IdxW-1:0] idx_o,
`endif
  output logic [NCLI-1:0] gnt_o
);

  logic            found;
  logic [IdxW-1:0] cand;

`ifndef RV_ARB_FIXED_PRIO_EN
  // Walk NCLI candidates starting one past the last grant; first requester wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = last_i;
    for (int k = 0; k < NCLI; k++) begin
      cand = (cand == IdxW'(NCLI - 1)) ? '0 : cand + IdxW'(1);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        idx_o       = cand;
        gnt_o[cand] = 1'b1;
      end
    end
  end
`else
  // Lowest-index requester wins.
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < NCLI; k++) begin
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
      end
      cand = cand + IdxW'(1);
    end
  end
`endif

endmodule

// File: rtl/sdram_rv_arbiter.sv
// Serialises NCLI clients onto the controller's toggle-handshake RISC-V port,
// hiding the toggle protocol and the post-ack read-data delay.
// Optional macro RV_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module sdram_rv_arbiter
  import sdram_rv_arbiter_pkg::*;
#(
  parameter int unsigned NCLI     = RV_ARB_NCLI,
  parameter int unsigned RD_DELAY = RV_ARB_RD_DELAY
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 sdram_busy_i,
  sdram_rv_arbiter_if.slave    cli_if,
  output logic [RV_ARB_AW-1:0] rv_addr_o,
  output logic [RV_ARB_DW-1:0] rv_din_o,
  output logic [1:0]           rv_ds_o,
  output logic                 rv_we_o,
  output logic                 rv_req_o,
  input  logic                 rv_req_ack_i,
  input  logic [RV_ARB_DW-1:0] rv_dout_i
);

  localparam int unsigned IdxW = idx_w(NCLI);
  localparam int unsigned CntW = idx_w(RD_DELAY);

  rv_arb_state_t        state_q;
  logic [NCLI-1:0]      gnt_q, ack_q;
  logic [CntW-1:0]      cnt_q;
  logic [RV_ARB_DW-1:0] rdata_q, din_q;
  logic [RV_ARB_AW-1:0] addr_q;
  logic [1:0]           ds_q;
  logic                 we_q, rv_req_q;

  logic [NCLI-1:0]      pick_gnt;
  logic [RV_ARB_AW-1:0] sel_addr;
  logic [RV_ARB_DW-1:0] sel_wdata;
  logic [1:0]           sel_ds;
  logic                 sel_we;

`ifndef RV_ARB_FIXED_PRIO_EN
  logic [IdxW-1:0] pick_idx, gidx_q, last_q;

  sdram_rv_arbiter_pick #(
    .NCLI (NCLI)
  ) u_pick (
    .req_i  (cli_if.c_req),
    .last_i (last_q),
    .idx_o  (pick_idx),
    .gnt_o  (pick_gnt)
  );
`else
  sdram_rv_arbiter_pick #(
    .NCLI (NCLI)
  ) u_pick (
    .req_i (cli_if.c_req),
    .gnt_o (pick_gnt)
  );
`endif

  // One-hot mux of the winning client's request fields.
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_ds    = '0;
    sel_we    = 1'b0;
    for (int i = 0; i < NCLI; i++) begin
      if (pick_gnt[i]) begin
        sel_addr  = cli_if.c_addr[i*RV_ARB_AW +: RV_ARB_AW];
        sel_wdata = cli_if.c_wdata[i*RV_ARB_DW +: RV_ARB_DW];
        sel_ds    = cli_if.c_ds[i*2 +: 2];
        sel_we    = cli_if.c_we[i];
      end
    end
  end

  // Transaction FSM; ack is launched on entry to DONE so it is high for the DONE cycle only.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= ARB_IDLE;
      rv_req_q <= rv_req_ack_i;  // match the controller so no request is pending
      gnt_q    <= '0;
      ack_q    <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      addr_q   <= '0;
      din_q    <= '0;
      ds_q     <= '0;
      we_q     <= 1'b0;
`ifndef RV_ARB_FIXED_PRIO_EN
      gidx_q   <= '0;
      last_q   <= IdxW'(NCLI - 1);  // client 0 searched first
`endif
    end else begin
      ack_q <= '0;
      unique case (state_q)
        ARB_IDLE: begin
          if (!sdram_busy_i && (|cli_if.c_req)) begin
            addr_q   <= sel_addr;
            din_q    <= sel_wdata;
            ds_q     <= sel_ds;
            we_q     <= sel_we;
            rv_req_q <= ~rv_req_q;
            gnt_q    <= pick_gnt;
`ifndef RV_ARB_FIXED_PRIO_EN
            gidx_q   <= pick_idx;
`endif
            state_q  <= ARB_WAIT_ACK;
          end
        end
        ARB_WAIT_ACK: begin
          if (rv_req_ack_i == rv_req_q) begin
            if (we_q) begin
              ack_q   <= gnt_q;
              state_q <= ARB_DONE;
            end else begin
              cnt_q   <= CntW'(RD_DELAY - 1);
              state_q <= ARB_RD_WAIT;
            end
          end
        end
        ARB_RD_WAIT: begin
          if (cnt_q == '0) begin
            rdata_q <= rv_dout_i;
            ack_q   <= gnt_q;
            state_q <= ARB_DONE;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        ARB_DONE: begin
`ifndef RV_ARB_FIXED_PRIO_EN
          last_q  <= gidx_q;
`endif
          state_q <= ARB_IDLE;
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign cli_if.c_ack   = ack_q;
  assign cli_if.c_rdata = rdata_q;
  assign rv_addr_o      = addr_q;
  assign rv_din_o       = din_q;
  assign rv_ds_o        = ds_q;
  assign rv_we_o        = we_q;
  assign rv_req_o       = rv_req_q;

endmodule

// File: tb/tb_sdram_rv_arbiter.sv
// Scoreboard bench for sdram_rv_arbiter with a toggle-handshake controller model.
module tb_sdram_rv_arbiter;

  localparam int unsigned NCLI     = 3;
  localparam int unsigned RD_DELAY = 3;

  logic        clk;
  logic        resetn;
  logic        sdram_busy;
  logic [19:0] rv_addr;
  logic [15:0] rv_din;
  logic [1:0]  rv_ds;
  logic        rv_we;
  logic        rv_req;
  logic        rv_req_ack;
  logic [15:0] rv_dout;

  sdram_rv_arbiter_if #(.NCLI(NCLI)) cif ();

  sdram_rv_arbiter #(
    .NCLI     (NCLI),
    .RD_DELAY (RD_DELAY)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .sdram_busy_i (sdram_busy),
    .cli_if       (cif),
    .rv_addr_o    (rv_addr),
    .rv_din_o     (rv_din),
    .rv_ds_o      (rv_ds),
    .rv_we_o      (rv_we),
    .rv_req_o     (rv_req),
    .rv_req_ack_i (rv_req_ack),
    .rv_dout_i    (rv_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          cli;
    bit          we;
    logic [15:0] rd;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          tog_n = 0;
  int          ack_n = 0;
  int          tog_cyc = 0;
  int          ctl_lat = 2;
  logic        prev_req = 1'b0;
  bit          ack_seen[3];
  logic [15:0] mem [0:1023];

  // Per-client job lists: each client presents jobs in order, advancing on its ack.
  bit          jw  [3][4];
  logic [19:0] ja  [3][4];
  logic [15:0] jd  [3][4];
  logic [1:0]  jds [3][4];
  int          njobs[3];
  int          jpos[3];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Controller model: answers a toggle after ctl_lat cycles; read data valid RD_DELAY later.
  initial begin : ctl_model
    bit          pending;
    int          lat_left;
    int          dcnt;
    logic [19:0] l_addr;
    logic [15:0] l_din, rd_word;
    logic [1:0]  l_ds;
    logic        l_we;
    pending    = 0;
    dcnt       = 0;
    lat_left   = 0;
    rd_word    = '0;
    rv_req_ack = 1'b1;
    rv_dout    = 16'hDEAD;
    forever begin
      @(posedge clk);
      #1;
      if (!resetn) begin
        pending = 0;
        dcnt    = 0;
      end else begin
        if (dcnt > 0) begin
          dcnt--;
          if (dcnt == 0) rv_dout = rd_word;
        end
        if (pending) begin
          if (lat_left > 1) begin
            lat_left--;
          end else begin
            n_vec++;
            if ({rv_addr, rv_din, rv_ds, rv_we} !== {l_addr, l_din, l_ds, l_we}) begin
              n_err++;
              $display("FAIL rv_stable: got %h/%h/%b/%b required %h/%h/%b/%b",
                       rv_addr, rv_din, rv_ds, rv_we, l_addr, l_din, l_ds, l_we);
            end
            if (l_we) begin
              if (l_ds[1]) mem[l_addr[9:0]][15:8] = l_din[15:8];
              if (l_ds[0]) mem[l_addr[9:0]][7:0]  = l_din[7:0];
            end else begin
              rd_word = mem[l_addr[9:0]];
            end
            rv_req_ack = ~rv_req_ack;
            tog_cyc    = cyc;
            pending    = 0;
            dcnt       = RD_DELAY;
            rv_dout    = 16'hDEAD;
          end
        end else if (rv_req !== rv_req_ack) begin
          pending  = 1;
          lat_left = ctl_lat;
          l_addr   = rv_addr;
          l_din    = rv_din;
          l_ds     = rv_ds;
          l_we     = rv_we;
        end
      end
    end
  end

  // Ack monitor: pops the scoreboard and checks client, latency and read data.
  initial begin : monitor
    exp_t       e;
    logic [2:0] exp_ack;
    int         exp_cyc;
    forever begin
      @(negedge clk);
      if (rv_req !== prev_req) tog_n++;
      prev_req = rv_req;
      if (cif.c_ack !== 3'b000) begin
        ack_n++;
        for (int i = 0; i < 3; i++) if (cif.c_ack[i] === 1'b1) ack_seen[i] = 1'b1;
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_ack: got c_ack=%b required none", cif.c_ack);
        end else begin
          e       = sb.pop_front();
          exp_ack = 3'(1 << e.cli);
          n_vec++;
          if (cif.c_ack !== exp_ack) begin
            n_err++;
            $display("FAIL ack_client: got c_ack=%b required %b", cif.c_ack, exp_ack);
          end
          exp_cyc = tog_cyc + (e.we ? 1 : RD_DELAY + 1);
          n_vec++;
          if (cyc != exp_cyc) begin
            n_err++;
            $display("FAIL ack_latency: got cycle %0d required %0d", cyc, exp_cyc);
          end
          if (!e.we) begin
            n_vec++;
            if (cif.c_rdata !== e.rd) begin
              n_err++;
              $display("FAIL read_data: got %h required %h", cif.c_rdata, e.rd);
            end
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      if (ack_seen[i]) begin
        ack_seen[i] = 1'b0;
        jpos[i]++;
      end
      if (jpos[i] < njobs[i]) begin
        cif.c_req[i]          = 1'b1;
        cif.c_we[i]           = jw[i][jpos[i]];
        cif.c_addr[i*20 +: 20]  = ja[i][jpos[i]];
        cif.c_wdata[i*16 +: 16] = jd[i][jpos[i]];
        cif.c_ds[i*2 +: 2]      = jds[i][jpos[i]];
      end else begin
        cif.c_req[i] = 1'b0;
      end
    end
  endtask

  task automatic clear_jobs();
    for (int i = 0; i < 3; i++) begin
      njobs[i]    = 0;
      jpos[i]     = 0;
      ack_seen[i] = 1'b0;
    end
    cif.c_req = '0;
  endtask

  task automatic add_job(input int c, input bit we, input logic [19:0] a,
                         input logic [15:0] d, input logic [1:0] ds);
    jw[c][njobs[c]]  = we;
    ja[c][njobs[c]]  = a;
    jd[c][njobs[c]]  = d;
    jds[c][njobs[c]] = ds;
    njobs[c]++;
  endtask

  task automatic push_exp(input int c, input bit we, input logic [15:0] rd);
    exp_t e;
    e.cli = c;
    e.we  = we;
    e.rd  = rd;
    sb.push_back(e);
  endtask

  task automatic wait_done(input string name, input int budget);
    int b = 0;
    while (sb.size() > 0 && b < budget) begin
      step();
      b++;
    end
    if (sb.size() > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout: got %0d acks outstanding required 0", name, sb.size());
      sb.delete();
    end
    step();
  endtask

  task automatic do_reset(input int n);
    resetn = 1'b0;
    clear_jobs();
    repeat (n) step();
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) step();
    n_vec++;
    if (rv_req !== rv_req_ack) begin
      n_err++;
      $display("FAIL reset_rv_req: got %b required %b", rv_req, rv_req_ack);
    end
    n_vec++;
    if (cif.c_ack !== 3'b000) begin
      n_err++;
      $display("FAIL reset_c_ack: got %b required 000", cif.c_ack);
    end
    n_vec++;
    if (cif.c_rdata !== 16'h0000) begin
      n_err++;
      $display("FAIL reset_c_rdata: got %h required 0000", cif.c_rdata);
    end
    n_vec++;
    if ({rv_addr, rv_din, rv_ds, rv_we} !== 39'd0) begin
      n_err++;
      $display("FAIL reset_rv_bus: got %h/%h/%b/%b required zero", rv_addr, rv_din, rv_ds, rv_we);
    end
    resetn = 1'b1;
    repeat (3) step();
    n_vec++;
    if (rv_req !== 1'b1) begin
      n_err++;
      $display("FAIL idle_rv_req: got %b required 1", rv_req);
    end
  endtask

  task automatic test_single_write();
    int t0 = tog_n;
    add_job(1, 1'b1, 20'h00010, 16'hBEEF, 2'b11);
    push_exp(1, 1'b1, 16'h0);
    wait_done("single_write", 40);
    n_vec++;
    if (tog_n - t0 != 1) begin
      n_err++;
      $display("FAIL write_toggles: got %0d required 1", tog_n - t0);
    end
    n_vec++;
    if (mem[10'h010] !== 16'hBEEF) begin
      n_err++;
      $display("FAIL write_mem: got %h required beef", mem[10'h010]);
    end
    clear_jobs();
  endtask

  task automatic test_single_read();
    add_job(0, 1'b0, 20'h00010, 16'h0, 2'b11);
    push_exp(0, 1'b0, 16'hBEEF);
    wait_done("single_read", 40);
    clear_jobs();
  endtask

  // ds=0 is still issued and acked, but leaves memory untouched.
  task automatic test_zero_ds();
    add_job(1, 1'b1, 20'h00010, 16'h0000, 2'b00);
    push_exp(1, 1'b1, 16'h0);
    wait_done("zero_ds", 40);
    n_vec++;
    if (mem[10'h010] !== 16'hBEEF) begin
      n_err++;
      $display("FAIL zero_ds_mem: got %h required beef", mem[10'h010]);
    end
    clear_jobs();
  endtask

  task automatic test_contention();
    do_reset(2);
    for (int i = 0; i < 3; i++) begin
      add_job(i, 1'b1, 20'h00200 + 20'(i), 16'hA000 + 16'(i), 2'b11);
      add_job(i, 1'b0, 20'h00200 + 20'(i), 16'h0, 2'b11);
    end
`ifdef RV_ARB_FIXED_PRIO_EN
    for (int i = 0; i < 3; i++) begin
      push_exp(i, 1'b1, 16'h0);
      push_exp(i, 1'b0, 16'hA000 + 16'(i));
    end
`else
    for (int i = 0; i < 3; i++) push_exp(i, 1'b1, 16'h0);
    for (int i = 0; i < 3; i++) push_exp(i, 1'b0, 16'hA000 + 16'(i));
`endif
    wait_done("contention", 200);
    clear_jobs();
  endtask

  task automatic test_busy_gating();
    int t0;
    int a0;
    sdram_busy = 1'b1;
    t0 = tog_n;
    a0 = ack_n;
    add_job(2, 1'b1, 20'h00300, 16'h1234, 2'b11);
    push_exp(2, 1'b1, 16'h0);
    repeat (100) step();
    n_vec++;
    if (tog_n != t0 || ack_n != a0) begin
      n_err++;
      $display("FAIL busy_hold: got %0d toggles %0d acks required 0 0", tog_n - t0, ack_n - a0);
    end
    sdram_busy = 1'b0;
    repeat (2) step();
    n_vec++;
    if (tog_n - t0 != 1) begin
      n_err++;
      $display("FAIL busy_release: got %0d toggles required 1", tog_n - t0);
    end
    wait_done("busy", 40);
    n_vec++;
    if (mem[10'h300] !== 16'h1234) begin
      n_err++;
      $display("FAIL busy_mem: got %h required 1234", mem[10'h300]);
    end
    clear_jobs();
  endtask

  task automatic test_reset_mid_read();
    int t0 = tog_n;
    int a0;
    int b = 0;
    ctl_lat = 6;
    add_job(0, 1'b0, 20'h00010, 16'h0, 2'b11);
    while (tog_n == t0 && b < 20) begin
      step();
      b++;
    end
    step();
    a0 = ack_n;
    do_reset(2);
    step();
    n_vec++;
    if (rv_req !== rv_req_ack) begin
      n_err++;
      $display("FAIL midrst_rv_req: got %b required %b", rv_req, rv_req_ack);
    end
    repeat (12) step();
    n_vec++;
    if (ack_n != a0) begin
      n_err++;
      $display("FAIL midrst_no_ack: got %0d acks required 0", ack_n - a0);
    end
    ctl_lat = 2;
    add_job(1, 1'b0, 20'h00010, 16'h0, 2'b11);
    push_exp(1, 1'b0, 16'hBEEF);
    wait_done("after_reset", 40);
    clear_jobs();
  endtask

  task automatic test_withdraw();
    int t0 = tog_n;
    int b = 0;
    add_job(2, 1'b1, 20'h00040, 16'h5A5A, 2'b11);
    push_exp(2, 1'b1, 16'h0);
    while (tog_n == t0 && b < 20) begin
      step();
      b++;
    end
    njobs[2]     = 0;
    cif.c_req[2] = 1'b0;
    wait_done("withdraw", 40);
    n_vec++;
    if (mem[10'h040] !== 16'h5A5A) begin
      n_err++;
      $display("FAIL withdraw_mem: got %h required 5a5a", mem[10'h040]);
    end
    clear_jobs();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
    resetn     = 1'b0;
    sdram_busy = 1'b0;
    cif.c_req   = '0;
    cif.c_we    = '0;
    cif.c_addr  = '0;
    cif.c_wdata = '0;
    cif.c_ds    = '0;
    clear_jobs();
    test_reset();
    test_single_write();
    test_single_read();
    test_zero_ds();
    test_contention();
    test_busy_gating();
    test_reset_mid_read();
    test_withdraw();
    repeat (3) step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
